fp_div_core: RTL and testbench

- Iterative IEEE-754 single-precision divider datapath; computes the quotient in1/in2 for normal operands.
- Feeds the combinational special-case/result-export stage directly. Its temp_result goes to that stage's temp_result input, alongside the same in1/in2.
- Special operands (zero, Inf, NaN) are overridden downstream. This block only guarantees a deterministic output for them.
- Restoring radix-2 mantissa division, one quotient bit per cycle, then a round-to-nearest-even stage.

---
 rtl/fp_div_core.sv | 153 +++++++++++++++
 tb/tb_fp_div_core.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_core.sv
// fp_div_core: iterative single-precision divider datapath.
// Restoring radix-2 mantissa division followed by an RNE rounding step.
module fp_div_core #(
  parameter int QBITS = 26,
  parameter int BIAS  = 127
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        busy,
  output logic        done,
  output logic [31:0] temp_result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_ROUND
  } state_t;

  localparam logic signed [9:0] EMAX = 10'sd255;
  localparam logic signed [9:0] EMIN = 10'sd0;

  state_t r_state;
  state_t w_next;

  logic                    r_sign;
  logic signed [9:0]       r_exp;
  logic [23:0]             r_m2;
  logic [24:0]             r_rem;
  logic [QBITS-1:0]        r_q;
  logic [4:0]              r_cnt;
  logic                    r_done;
  logic [31:0]             r_result;

  logic signed [9:0]       w_exp_in;
  logic                    w_ge;
  logic [24:0]             w_diff;
  logic [24:0]             w_rem_nxt;
  logic [QBITS-1:0]        w_q_nxt;

  logic [23:0]             w_mant;
  logic                    w_guard;
  logic                    w_sticky;
  logic signed [9:0]       w_e;
  logic                    w_inc;
  logic [24:0]             w_sum;
  logic [23:0]             w_mant_f;
  logic signed [9:0]       w_e_f;
  logic [31:0]             w_result;

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign temp_result = r_result;

  assign w_exp_in = {2'b00, in1[30:23]}
                  - {2'b00, in2[30:23]}
                  + BIAS[9:0];

  // one restoring step: compare, conditionally subtract, shift
  always_comb begin
    w_ge      = (r_rem >= {1'b0, r_m2});
    w_diff    = w_ge ? (r_rem - {1'b0, r_m2}) : r_rem;
    w_rem_nxt = {w_diff[23:0], 1'b0};
    w_q_nxt   = {r_q[QBITS-2:0], w_ge};
  end

  // normalize, round to nearest even, then pack / clamp
  always_comb begin
    w_mant   = r_q[24:1];
    w_guard  = r_q[0];
    w_sticky = |r_rem;
    w_e      = r_exp - 10'sd1;
    if (r_q[25]) begin
      w_mant   = r_q[25:2];
      w_guard  = r_q[1];
      w_sticky = r_q[0] | (|r_rem);
      w_e      = r_exp;
    end
    w_inc    = w_guard & (w_sticky | w_mant[0]);
    w_sum    = {1'b0, w_mant} + {24'd0, w_inc};
    w_mant_f = w_sum[23:0];
    w_e_f    = w_e;
    if (w_sum[24]) begin
      w_mant_f = 24'h800000;
      w_e_f    = w_e + 10'sd1;
    end
    if (w_e_f >= EMAX)
      w_result = {r_sign, 8'hFF, 23'h0};
    else if (w_e_f <= EMIN)
      w_result = {r_sign, 31'h0};
    else
      w_result = {r_sign, w_e_f[7:0], w_mant_f[22:0]};
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_DIV;
      S_DIV:   if (r_cnt == 5'd0) w_next = S_ROUND;
      S_ROUND: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // operand capture, iteration and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_m2     <= '0;
      r_rem    <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sign <= in1[31] ^ in2[31];
            r_exp  <= w_exp_in;
            r_m2   <= {1'b1, in2[22:0]};
            r_rem  <= {2'b01, in1[22:0]};
            r_q    <= '0;
            r_cnt  <= 5'(QBITS - 1);
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt - 5'd1;
        end
        S_ROUND: begin
          r_result <= w_result;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_core.sv
// tb_fp_div_core: directed checks of the iterative divider.
// Each scenario task drives stimulus and compares inline.
module tb_fp_div_core;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        busy;
  logic        done;
  logic [31:0] temp_result;

  int checks = 0;
  int errors = 0;

  fp_div_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in1         (in1),
    .in2         (in2),
    .busy        (busy),
    .done        (done),
    .temp_result (temp_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // caller sits just after an edge; returns in the done cycle
  task automatic run_op(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res,
    output int          lat,
    output int          bcnt,
    output bit          ok
  );
    ok = 1'b0; lat = 0; bcnt = 0;
    start = 1'b1; in1 = a; in2 = b;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (busy) bcnt++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    res = temp_result;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in1 = '0; in2 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b want 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL reset_done got %b want 0", done);
    end
    checks++;
    if (temp_result !== 32'h0) begin
      errors++; $display("FAIL reset_result got %h want 00000000", temp_result);
    end
  endtask

  task automatic test_basic();
    logic [31:0] r; int lat; int bc; bit ok;
    idle_cycle();
    run_op(32'h40C00000, 32'h40000000, r, lat, bc, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL basic_timeout got no done want done");
    end
    checks++;
    if (r !== 32'h40400000) begin
      errors++; $display("FAIL basic_result got %h want 40400000", r);
    end
    checks++;
    if (lat !== 28) begin
      errors++; $display("FAIL basic_latency got %0d want 28", lat);
    end
    checks++;
    if (bc !== 27) begin
      errors++; $display("FAIL basic_busy_cycles got %0d want 27", bc);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL basic_busy_at_done got %b want 0", busy);
    end
    idle_cycle();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse got %b want 0", done);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] va [6] = '{32'h3F800000, 32'hC0C00000, 32'h3F800000,
                            32'h7F000000, 32'h80800000, 32'h40E00000};
    logic [31:0] vb [6] = '{32'h40400000, 32'h40000000, 32'h3F800000,
                            32'h00800000, 32'h7F000000, 32'h40400000};
    logic [31:0] ve [6] = '{32'h3EAAAAAB, 32'hC0400000, 32'h3F800000,
                            32'h7F800000, 32'h80000000, 32'h40155555};
    logic [31:0] r; int lat; int bc; bit ok;
    for (int i = 0; i < 6; i++) begin
      idle_cycle();
      run_op(va[i], vb[i], r, lat, bc, ok);
      checks++;
      if (ok !== 1'b1 || r !== ve[i]) begin
        errors++;
        $display("FAIL vec%0d %h/%h got %h done=%b want %h",
                 i, va[i], vb[i], r, ok, ve[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat; bit ok; int extra;
    idle_cycle();
    ok = 1'b0; lat = 0;
    start = 1'b1; in1 = 32'h40C00000; in2 = 32'h40000000;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (lat == 5) begin
        start = 1'b1; in1 = 32'h3F800000; in2 = 32'h40400000;
      end
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (ok !== 1'b1 || temp_result !== 32'h40400000) begin
      errors++;
      $display("FAIL ignore_result got %h done=%b want 40400000",
               temp_result, ok);
    end
    checks++;
    if (lat !== 28) begin
      errors++; $display("FAIL ignore_latency got %0d want 28", lat);
    end
    extra = 0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL ignore_not_queued got %0d active cycles want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int lat; int bc; bit ok;
    idle_cycle();
    run_op(32'h40C00000, 32'h40000000, r, lat, bc, ok);
    run_op(32'h3F800000, 32'h40400000, r, lat, bc, ok);
    checks++;
    if (ok !== 1'b1 || r !== 32'h3EAAAAAB) begin
      errors++;
      $display("FAIL b2b_result got %h done=%b want 3EAAAAAB", r, ok);
    end
    checks++;
    if (lat !== 28) begin
      errors++; $display("FAIL b2b_latency got %0d want 28", lat);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] r; int lat; int bc; bit ok; int seen;
    idle_cycle();
    start = 1'b1; in1 = 32'h40E00000; in2 = 32'h40400000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL midrst_busy got %b want 0", busy);
    end
    checks++;
    if (temp_result !== 32'h0) begin
      errors++; $display("FAIL midrst_result got %h want 00000000", temp_result);
    end
    seen = 0;
    for (int i = 0; i < 35; i++) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL midrst_no_done got %0d pulses want 0", seen);
    end
    run_op(32'h40E00000, 32'h40400000, r, lat, bc, ok);
    checks++;
    if (ok !== 1'b1 || r !== 32'h40155555) begin
      errors++;
      $display("FAIL midrst_next_op got %h done=%b want 40155555", r, ok);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
